// File: rtl/burst_write_sequencer_pkg.sv
// Shared types and constants for the burst write sequencer: FSM state encoding
// and watchdog sizing.
package bws_pkg;

  typedef enum logic [3:0] {
    IDLE,
    POLL_REQ,
    POLL_WAIT,
    WR_GET,
    WR_REQ,
    WR_WAIT,
    STOP_REQ,
    STOP_WAIT,
    ERR
  } bws_state_t;

  localparam int unsigned BWS_TIMEOUT = 1024;
  localparam int unsigned BWS_WD_W    = $clog2(BWS_TIMEOUT + 1);

  function automatic logic is_wait(input bws_state_t s);
    return (s == POLL_WAIT) || (s == WR_WAIT) || (s == STOP_WAIT);
  endfunction

endpackage

// File: rtl/burst_write_sequencer_if.sv
// User-master bus between the sequencer (master modport) and the PCIe/Avalon
// user master (slave modport): n_action/rdwr_cntl request, master_idle completion.
interface burst_write_sequencer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          n_action;
  logic          rdwr_cntl;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          master_idle;
  logic          read_valid;
  logic [DW-1:0] read_data;

  modport master (
    output n_action, rdwr_cntl, address, write_data,
    input  master_idle, read_valid, read_data
  );

  modport slave (
    input  n_action, rdwr_cntl, address, write_data,
    output master_idle, read_valid, read_data
  );
endinterface

// File: rtl/burst_write_sequencer_watchdog.sv
// Per-transaction watchdog: counts cycles while run is high, restarts on clear,
// and flags the TIMEOUT-th consecutive running cycle.
module bws_watchdog
  import bws_pkg::*;
#(
  parameter int unsigned TIMEOUT = BWS_TIMEOUT,
  parameter int unsigned W       = BWS_WD_W
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  logic [W-1:0] cnt;

  assign expired = run && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/burst_write_sequencer.sv
// Polls a status word; on START_CODE streams NUM_WORDS source words to
// consecutive addresses, then writes STOP_CODE. Watchdog aborts stalled waits.
module burst_write_sequencer
  import bws_pkg::*;
#(
  parameter int unsigned   AW          = 32,
  parameter int unsigned   DW          = 32,
  parameter int unsigned   NUM_WORDS   = 16,
  parameter int unsigned   CNT_W       = $clog2(NUM_WORDS + 1),
  parameter logic [AW-1:0] POLL_ADDR   = AW'(32'h0),
  parameter logic [AW-1:0] WR_BASE     = AW'(32'h100),
  parameter int unsigned   ADDR_STRIDE = 4,
  parameter logic [AW-1:0] STOP_ADDR   = AW'(32'h4),
  parameter logic [DW-1:0] START_CODE  = DW'(32'h53),
  parameter logic [DW-1:0] STOP_CODE   = DW'(32'h0),
  parameter int unsigned   TIMEOUT     = BWS_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    enable,
  burst_write_sequencer_if.master bus,
  input  logic                    src_valid,
  input  logic [DW-1:0]           src_data,
  output logic                    src_ready,
  output logic [CNT_W-1:0]        words_done,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  bws_state_t     state, state_next;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic           match_q, first_q, done_q;
  logic           wd_expired, start_hit, complete, cnt_last;

  // master_idle is still high from the previous transaction in the first WAIT cycle
  assign complete  = bus.master_idle && !first_q;
  assign start_hit = bus.read_valid && (bus.read_data == START_CODE);
  assign cnt_last  = (cnt_q == CNT_W'(NUM_WORDS - 1));

  bws_watchdog #(.TIMEOUT(TIMEOUT), .W(WD_W)) u_watchdog (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (state_next != state),
    .run     (is_wait(state)),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.n_action  = 1'b1;
    bus.rdwr_cntl = 1'b0;
    src_ready     = 1'b0;
    unique case (state)
      IDLE:      if (enable) state_next = POLL_REQ;
      POLL_REQ: begin
        bus.n_action = 1'b0;
        state_next   = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (complete)        state_next = (match_q || start_hit) ? WR_GET : IDLE;
        else if (wd_expired) state_next = ERR;
      end
      WR_GET: begin
        src_ready = src_valid;
        if (src_valid) state_next = WR_REQ;
      end
      WR_REQ: begin
        bus.n_action  = 1'b0;
        bus.rdwr_cntl = 1'b1;
        state_next    = WR_WAIT;
      end
      WR_WAIT: begin
        if (complete)        state_next = cnt_last ? STOP_REQ : WR_GET;
        else if (wd_expired) state_next = ERR;
      end
      STOP_REQ: begin
        bus.n_action  = 1'b0;
        bus.rdwr_cntl = 1'b1;
        state_next    = STOP_WAIT;
      end
      STOP_WAIT: begin
        if (complete)        state_next = IDLE;
        else if (wd_expired) state_next = ERR;
      end
      ERR:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Address and data are loaded on entry to each REQ state and held until the next one
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      first_q <= (state == POLL_REQ) || (state == WR_REQ) || (state == STOP_REQ);
      done_q  <= (state == STOP_WAIT) && complete;
      if (state == IDLE && enable) begin
        cnt_q  <= '0;
        addr_q <= POLL_ADDR;
      end
      if (state == POLL_REQ)                    match_q <= 1'b0;
      else if (state == POLL_WAIT && start_hit) match_q <= 1'b1;
      if (state == WR_GET && src_valid) begin
        wdata_q <= src_data;
        addr_q  <= WR_BASE + AW'(cnt_q) * AW'(ADDR_STRIDE);
      end
      if (state == WR_WAIT && complete) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_last) begin
          addr_q  <= STOP_ADDR;
          wdata_q <= STOP_CODE;
        end
      end
    end
  end

  assign bus.address    = addr_q;
  assign bus.write_data = wdata_q;
  assign words_done     = cnt_q;
  assign busy           = (state != IDLE);
  assign done           = done_q;
  assign error          = (state == ERR);
endmodule

// File: tb/tb_burst_write_sequencer.sv
// Scoreboard bench for burst_write_sequencer: stimulus pushes the expected
// transaction list, a negedge monitor pops and compares every request.
module tb_burst_write_sequencer;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 16;
  localparam int unsigned CW = $clog2(NW + 1);
  localparam int unsigned TO = 1024;
  localparam int unsigned STRIDE = 4;
  localparam logic [31:0] POLL_A = 32'h0;
  localparam logic [31:0] BASE   = 32'h100;
  localparam logic [31:0] STOP_A = 32'h4;
  localparam logic [31:0] START  = 32'h53;
  localparam logic [31:0] STOPC  = 32'h0;
  localparam int unsigned M_NOM = 0;
  localparam int unsigned M_STUCK = 1;

  logic clk = 1'b0, n_rst = 1'b0, enable = 1'b0;
  logic src_valid = 1'b0, src_ready, busy, done, error;
  logic [DW-1:0] src_data = '0;
  logic [CW-1:0] words_done;

  burst_write_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  burst_write_sequencer #(
    .AW(AW), .DW(DW), .NUM_WORDS(NW), .CNT_W(CW), .POLL_ADDR(POLL_A),
    .WR_BASE(BASE), .ADDR_STRIDE(STRIDE), .STOP_ADDR(STOP_A),
    .START_CODE(START), .STOP_CODE(STOPC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .bus(bus.master),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .words_done(words_done), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          exp_q[$];
  logic [DW-1:0] status_q[$];
  logic [DW-1:0] src_q[$];
  int unsigned   req_cyc_q[$];
  int unsigned   checks = 0, errors = 0;
  int unsigned   cyc = 0, done_cnt = 0, err_cnt = 0, ready_cnt = 0, req_cnt = 0;
  int unsigned   err_cyc = 0, last_req_cyc = 0, src_idx = 0;
  int unsigned   mode = M_NOM, lat_min = 3, lat_max = 3;
  bit            gap = 1'b0, hang_en = 1'b0;
  logic [AW-1:0] hang_addr = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Reference model: one poll read, then NUM_WORDS sequential writes of source data, then STOP
  function automatic void expect_burst(input bit hit, input int unsigned nwr, input bit stop);
    txn_t t;
    t.wr = 1'b0; t.addr = POLL_A; t.data = '0;
    exp_q.push_back(t);
    if (hit) begin
      for (int unsigned i = 0; i < nwr; i++) begin
        t.wr = 1'b1; t.addr = BASE + i * STRIDE; t.data = src_q[i];
        exp_q.push_back(t);
      end
      if (stop) begin
        t.wr = 1'b1; t.addr = STOP_A; t.data = STOPC;
        exp_q.push_back(t);
      end
    end
  endfunction

  // Monitor / scoreboard
  initial begin
    txn_t e;
    bit have_prev = 1'b0, hold_valid = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic [DW-1:0] hold_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!n_rst) begin
        have_prev = 1'b0; hold_valid = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (error) begin err_cnt++; err_cyc = cyc; end
        if (bus.n_action == 1'b0) begin
          req_cnt++;
          if (have_prev) check("req_spacing_ge3", 64'(cyc - last_req_cyc >= 3), 64'd1);
          have_prev = 1'b1; last_req_cyc = cyc;
          req_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got rdwr=%0b addr=0x%0h, required none", bus.rdwr_cntl, bus.address);
          end else begin
            e = exp_q.pop_front();
            check("req_rdwr", 64'(bus.rdwr_cntl), 64'(e.wr));
            check("req_addr", 64'(bus.address), 64'(e.addr));
            if (e.wr) check("req_data", 64'(bus.write_data), 64'(e.data));
          end
          hold_valid = 1'b1; hold_addr = bus.address; hold_data = bus.write_data;
        end else if (hold_valid) begin
          check("hold_addr", 64'(bus.address), 64'(hold_addr));
          check("hold_data", 64'(bus.write_data), 64'(hold_data));
        end
      end
    end
  end

  // User master model
  initial begin
    bit pending = 1'b0, is_rd = 1'b0, hang = 1'b0;
    int unsigned age = 0, lat = 1;
    bus.master_idle = 1'b1; bus.read_valid = 1'b0; bus.read_data = '0;
    forever begin
      @(negedge clk);
      bus.read_valid = 1'b0;
      if (!n_rst) begin
        pending = 1'b0; bus.master_idle = 1'b1;
      end else if (pending && !busy) begin
        pending = 1'b0; bus.master_idle = 1'b1;
      end else if (pending) begin
        age++;
        if ((mode == M_STUCK && age == 1) || (mode != M_STUCK && !hang && age >= lat)) begin
          bus.master_idle = 1'b1;
          if (is_rd) begin
            bus.read_valid = 1'b1;
            bus.read_data  = (status_q.size() != 0) ? status_q.pop_front() : '0;
          end
          pending = 1'b0;
        end
      end else if (bus.n_action == 1'b0) begin
        pending = 1'b1; age = 0; is_rd = !bus.rdwr_cntl;
        hang = hang_en && bus.rdwr_cntl && (bus.address == hang_addr);
        lat = $urandom_range(lat_max, lat_min);
        if (mode != M_STUCK) bus.master_idle = 1'b0;
      end
    end
  end

  // Pixel source model
  initial begin
    forever begin
      @(negedge clk);
      if (src_idx < src_q.size() && (!gap || $urandom_range(3, 0) == 0)) begin
        src_valid = 1'b1; src_data = src_q[src_idx];
      end else begin
        src_valid = 1'b0; src_data = $urandom;
      end
      #1;
      if (src_ready) begin
        ready_cnt++;
        if (src_valid) src_idx++;
        else begin
          checks++; errors++;
          $display("FAIL src_ready_without_valid: got 1, required 0");
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_n_action"}, 64'(bus.n_action), 64'd1);
    check({tag, "_rdwr"}, 64'(bus.rdwr_cntl), 64'd0);
    check({tag, "_address"}, 64'(bus.address), 64'd0);
    check({tag, "_write_data"}, 64'(bus.write_data), 64'd0);
    check({tag, "_src_ready"}, 64'(src_ready), 64'd0);
    check({tag, "_words_done"}, 64'(words_done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  task automatic pulse_enable();
    int unsigned n = 0;
    @(negedge clk);
    enable = 1'b1;
    do begin @(negedge clk); n++; end while (!busy && n < 5);
    enable = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check({name, "_finished_in_budget"}, 64'(n < budget), 64'd1);
  endtask

  task automatic load_source();
    src_q.delete();
    for (int i = 0; i < int'(NW) + 2; i++) src_q.push_back($urandom);
    src_idx = 0;
  endtask

  task automatic run_burst(input string name, input logic [DW-1:0] status, input bit gapped,
                           input int unsigned lmin, input int unsigned lmax, input int unsigned m);
    int unsigned d0 = done_cnt, r0 = ready_cnt, e0 = err_cnt;
    bit hit = (status == START);
    mode = m; gap = gapped; lat_min = lmin; lat_max = lmax;
    load_source();
    status_q.push_back(status);
    expect_burst(hit, NW, 1'b1);
    pulse_enable();
    wait_idle(name, 6000);
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'(hit));
    check({name, "_src_consumed"}, 64'(ready_cnt - r0), hit ? 64'(NW) : 64'd0);
    check({name, "_error_pulses"}, 64'(err_cnt - e0), 64'd0);
    check({name, "_words_done"}, 64'(words_done), hit ? 64'(NW) : 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n, base, d0, r0, e0;
    #23;
    check_reset_outputs("reset");
    @(negedge clk); #2; n_rst = 1'b1;

    // Miss: two polls with enable held high, re-poll one IDLE cycle after each miss
    mode = M_NOM; lat_min = 3; lat_max = 3; gap = 1'b0;
    src_q.delete(); src_idx = 0;
    base = req_cyc_q.size(); r0 = ready_cnt;
    status_q.push_back(32'h0); status_q.push_back(32'h12);
    expect_burst(1'b0, 0, 1'b0); expect_burst(1'b0, 0, 1'b0);
    @(negedge clk); enable = 1'b1;
    n = 0;
    while (req_cnt < 2 && n < 100) begin @(negedge clk); n++; end
    enable = 1'b0;
    wait_idle("miss", 100);
    check("miss_repoll_spacing", (req_cyc_q.size() >= base + 2) ? 64'(req_cyc_q[base+1] - req_cyc_q[base]) : 64'd0, 64'd5);
    check("miss_src_consumed", 64'(ready_cnt - r0), 64'd0);

    run_burst("nominal", START, 1'b0, 3, 3, M_NOM);
    run_burst("gapped", START, 1'b1, 1, 4, M_NOM);
    run_burst("stuck_idle", START, 1'b0, 1, 1, M_STUCK);

    // Watchdog: master never completes word 5
    d0 = done_cnt; r0 = ready_cnt; e0 = err_cnt;
    mode = M_NOM; gap = 1'b0; lat_min = 3; lat_max = 3;
    hang_en = 1'b1; hang_addr = BASE + 5 * STRIDE;
    load_source();
    status_q.push_back(START);
    expect_burst(1'b1, 6, 1'b0);
    pulse_enable();
    wait_idle("timeout", 3000);
    hang_en = 1'b0;
    check("timeout_error_pulses", 64'(err_cnt - e0), 64'd1);
    check("timeout_error_delay", 64'(err_cyc - last_req_cyc), 64'(TO + 1));
    check("timeout_words_done", 64'(words_done), 64'd5);
    check("timeout_done_pulses", 64'(done_cnt - d0), 64'd0);
    check("timeout_src_consumed", 64'(ready_cnt - r0), 64'd6);
    check("timeout_busy", 64'(busy), 64'd0);

    // Reset during WR_WAIT of word 8
    mode = M_NOM; gap = 1'b0; lat_min = 4; lat_max = 4;
    load_source();
    status_q.push_back(START);
    expect_burst(1'b1, 9, 1'b0);
    base = req_cnt;
    pulse_enable();
    n = 0;
    while (req_cnt < base + 10 && n < 2000) begin @(negedge clk); n++; end
    check("midburst_reached_word8", 64'(n < 2000), 64'd1);
    @(negedge clk); #2;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    check("midburst_pending_txns", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2; n_rst = 1'b1;
    run_burst("after_reset", START, 1'b0, 3, 3, M_NOM);

    for (int i = 0; i < 5; i++) begin
      run_burst("random", ($urandom_range(1, 0) == 1) ? START : DW'($urandom_range(255, 0)),
                1'($urandom_range(1, 0)), 1, 5, $urandom_range(1, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
